// File: rtl/axi_llc_miss_sched.sv
// Routes looked-up descriptors to the hit or miss pipeline and drives the per-ID miss counters.
// Accept-to-valid latency is 2 cycles unless stalled; completions are granted combinationally.
module axi_llc_miss_sched #(
   parameter int unsigned IdWidth    = 6,
   parameter bit          RoundRobin = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               desc_valid_i,
   output logic               desc_ready_o,
   input  logic [IdWidth-1:0] desc_id_i,
   input  logic               desc_rw_i,
   input  logic               desc_miss_i,
   output logic               hit_valid_o,
   input  logic               hit_ready_i,
   output logic               miss_valid_o,
   input  logic               miss_ready_i,
   output logic [IdWidth-1:0] out_id_o,
   output logic               out_rw_o,
   input  logic               done_r_valid_i,
   input  logic [IdWidth-1:0] done_r_id_i,
   output logic               done_r_ready_o,
   input  logic               done_w_valid_i,
   input  logic [IdWidth-1:0] done_w_id_i,
   output logic               done_w_ready_o,
   output logic               cnt_up_valid_o,
   output logic [IdWidth-1:0] cnt_up_id_o,
   output logic               cnt_up_rw_o,
   output logic               cnt_down_valid_o,
   output logic [IdWidth-1:0] cnt_down_id_o,
   output logic               cnt_down_rw_o,
   input  logic               to_miss_i,
   input  logic               stall_i,
   output logic               busy_o
);

   typedef enum logic [1:0] {IDLE, EVAL, SEND_HIT, SEND_MISS} state_e;

   state_e             state_q, state_d;
   logic [IdWidth-1:0] id_q, id_d;
   logic               rw_q, rw_d;
   logic               miss_q, miss_d;
   logic               rr_w_q, rr_w_d;
   logic               route_miss;
   logic               grant_w;
   logic               both_done;

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      rw_d       = rw_q;
      miss_d     = miss_q;
      route_miss = miss_q | to_miss_i;
      case (state_q)
         IDLE: begin
            if (desc_valid_i) begin
               id_d    = desc_id_i;
               rw_d    = desc_rw_i;
               miss_d  = desc_miss_i;
               state_d = EVAL;
            end
         end
         EVAL: begin
            // A saturated counter cannot take another count-up, so wait here.
            if (route_miss) begin
               if (!stall_i) state_d = SEND_MISS;
            end else begin
               state_d = SEND_HIT;
            end
         end
         SEND_HIT:  if (hit_ready_i)  state_d = IDLE;
         SEND_MISS: if (miss_ready_i) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   assign desc_ready_o   = (state_q == IDLE);
   assign busy_o         = (state_q != IDLE);
   assign hit_valid_o    = (state_q == SEND_HIT);
   assign miss_valid_o   = (state_q == SEND_MISS);
   assign out_id_o       = id_q;
   assign out_rw_o       = rw_q;
   assign cnt_up_id_o    = id_q;
   assign cnt_up_rw_o    = rw_q;
   assign cnt_up_valid_o = (state_q == SEND_MISS) & miss_ready_i;

   // Completion arbiter: rr_w_q names the side that wins the next tie.
   assign both_done        = done_r_valid_i & done_w_valid_i;
   assign grant_w          = done_w_valid_i & (~done_r_valid_i | (RoundRobin & rr_w_q));
   assign done_w_ready_o   = grant_w;
   assign done_r_ready_o   = done_r_valid_i & ~grant_w;
   assign cnt_down_valid_o = done_r_valid_i | done_w_valid_i;
   assign cnt_down_id_o    = grant_w ? done_w_id_i : done_r_id_i;
   assign cnt_down_rw_o    = grant_w;

   always_comb begin
      rr_w_d = rr_w_q;
      if (RoundRobin && both_done) rr_w_d = ~rr_w_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         id_q    <= '0;
         rw_q    <= 1'b0;
         miss_q  <= 1'b0;
         rr_w_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         rw_q    <= rw_d;
         miss_q  <= miss_d;
         rr_w_q  <= rr_w_d;
      end
   end

endmodule

// File: tb/tb_axi_llc_miss_sched.sv
// Randomized and directed bench for axi_llc_miss_sched against a transaction-level model
// that includes a simple per-ID outstanding-miss counter block.
module tb_axi_llc_miss_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       desc_valid, desc_rw, desc_miss;
   logic [5:0] desc_id;
   logic       hit_ready, miss_ready;
   logic       done_r_valid, done_w_valid;
   logic [5:0] done_r_id, done_w_id;
   logic       to_miss, stall;

   logic       desc_ready, hit_valid, miss_valid, out_rw, busy;
   logic [5:0] out_id, cnt_up_id, cnt_down_id;
   logic       done_r_ready, done_w_ready, cnt_up_valid, cnt_up_rw, cnt_down_valid, cnt_down_rw;

   logic       f_desc_ready, f_hit_valid, f_miss_valid, f_out_rw, f_busy;
   logic [5:0] f_out_id, f_cnt_up_id, f_cnt_down_id;
   logic       f_done_r_ready, f_done_w_ready, f_cnt_up_valid, f_cnt_up_rw, f_cnt_down_valid, f_cnt_down_rw;

   int  n_checks = 0;
   int  n_errors = 0;
   int  outstanding [0:63];
   bit  rr_ptr_w = 1'b0;

   always #5 clk = ~clk;

   // Counter block model: any outstanding miss on the held ID is a conflict.
   always_comb to_miss = busy && (outstanding[out_id] != 0);

   axi_llc_miss_sched #(.IdWidth(6), .RoundRobin(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .desc_valid_i(desc_valid), .desc_ready_o(desc_ready), .desc_id_i(desc_id),
      .desc_rw_i(desc_rw), .desc_miss_i(desc_miss),
      .hit_valid_o(hit_valid), .hit_ready_i(hit_ready),
      .miss_valid_o(miss_valid), .miss_ready_i(miss_ready),
      .out_id_o(out_id), .out_rw_o(out_rw),
      .done_r_valid_i(done_r_valid), .done_r_id_i(done_r_id), .done_r_ready_o(done_r_ready),
      .done_w_valid_i(done_w_valid), .done_w_id_i(done_w_id), .done_w_ready_o(done_w_ready),
      .cnt_up_valid_o(cnt_up_valid), .cnt_up_id_o(cnt_up_id), .cnt_up_rw_o(cnt_up_rw),
      .cnt_down_valid_o(cnt_down_valid), .cnt_down_id_o(cnt_down_id), .cnt_down_rw_o(cnt_down_rw),
      .to_miss_i(to_miss), .stall_i(stall), .busy_o(busy)
   );

   axi_llc_miss_sched #(.IdWidth(6), .RoundRobin(1'b0)) dut_fixed (
      .clk_i(clk), .rst_ni(rst_n),
      .desc_valid_i(desc_valid), .desc_ready_o(f_desc_ready), .desc_id_i(desc_id),
      .desc_rw_i(desc_rw), .desc_miss_i(desc_miss),
      .hit_valid_o(f_hit_valid), .hit_ready_i(hit_ready),
      .miss_valid_o(f_miss_valid), .miss_ready_i(miss_ready),
      .out_id_o(f_out_id), .out_rw_o(f_out_rw),
      .done_r_valid_i(done_r_valid), .done_r_id_i(done_r_id), .done_r_ready_o(f_done_r_ready),
      .done_w_valid_i(done_w_valid), .done_w_id_i(done_w_id), .done_w_ready_o(f_done_w_ready),
      .cnt_up_valid_o(f_cnt_up_valid), .cnt_up_id_o(f_cnt_up_id), .cnt_up_rw_o(f_cnt_up_rw),
      .cnt_down_valid_o(f_cnt_down_valid), .cnt_down_id_o(f_cnt_down_id), .cnt_down_rw_o(f_cnt_down_rw),
      .to_miss_i(to_miss), .stall_i(stall), .busy_o(f_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One descriptor end to end; called at edge+1 with the DUT idle.
   task automatic run_desc(input int id, input bit rw, input bit miss, input int stall_cyc, input int hold_cyc);
      bit exp_miss;
      exp_miss = miss || (outstanding[id] != 0);
      chk("idle_ready", desc_ready, 1);
      desc_valid = 1; desc_id = 6'(id); desc_rw = rw; desc_miss = miss;
      stall = (stall_cyc > 0); hit_ready = 0; miss_ready = 0;
      tick();
      desc_valid = 0; desc_id = 6'h3f; desc_miss = 0;
      chk("eval_busy", busy, 1);
      chk("eval_ready", desc_ready, 0);
      chk("eval_valids", {hit_valid, miss_valid}, 0);
      if (exp_miss) begin
         for (int i = 0; i < stall_cyc; i++) begin
            tick();
            chk("stall_hold", {hit_valid, miss_valid}, 0);
            chk("stall_busy", busy, 1);
         end
         stall = 0;
      end
      tick();
      stall = 0;
      chk("hit_valid", hit_valid, !exp_miss);
      chk("miss_valid", miss_valid, exp_miss);
      chk("fixed_valids", {f_hit_valid, f_miss_valid}, {!exp_miss, exp_miss});
      chk("out_id", out_id, id);
      chk("out_rw", out_rw, rw);
      chk("up_early", cnt_up_valid, 0);
      for (int i = 0; i < hold_cyc; i++) begin
         tick();
         chk("hold_valids", {hit_valid, miss_valid}, {!exp_miss, exp_miss});
         chk("hold_payload", {out_id, out_rw}, {6'(id), rw});
      end
      hit_ready = 1; miss_ready = 1;
      #1;
      chk("up_valid", cnt_up_valid, exp_miss);
      if (exp_miss) chk("up_idrw", {cnt_up_id, cnt_up_rw}, {6'(id), rw});
      tick();
      hit_ready = 0; miss_ready = 0;
      chk("post_valids", {hit_valid, miss_valid}, 0);
      chk("post_ready", desc_ready, 1);
      chk("post_busy", busy, 0);
      chk("up_once", cnt_up_valid, 0);
      if (exp_miss) outstanding[id]++;
   endtask

   // Presents completions for one cycle and checks both arbiter flavours.
   task automatic do_done(input bit rv, input int rid, input bit wv, input int wid);
      bit gw, gw_f;
      done_r_valid = rv; done_r_id = 6'(rid); done_w_valid = wv; done_w_id = 6'(wid);
      #1;
      gw   = wv && (!rv || rr_ptr_w);
      gw_f = wv && !rv;
      chk("down_valid", cnt_down_valid, rv || wv);
      chk("rdy_r", done_r_ready, rv && !gw);
      chk("rdy_w", done_w_ready, gw);
      if (rv || wv) begin
         chk("down_rw", cnt_down_rw, gw);
         chk("down_id", cnt_down_id, gw ? wid : rid);
         chk("fixed_rw", f_cnt_down_rw, gw_f);
         chk("fixed_id", f_cnt_down_id, gw_f ? wid : rid);
         chk("fixed_rdy", {f_done_r_ready, f_done_w_ready}, {rv && !gw_f, gw_f});
      end
      tick();
      if (rv && wv) rr_ptr_w = !rr_ptr_w;
      done_r_valid = 0; done_w_valid = 0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) outstanding[i] = 0;
      rst_n = 0; desc_valid = 0; desc_id = 0; desc_rw = 0; desc_miss = 0;
      hit_ready = 0; miss_ready = 0; done_r_valid = 0; done_r_id = 0;
      done_w_valid = 0; done_w_id = 0; stall = 0;
      tick(); tick();
      chk("rst_ready", desc_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valids", {hit_valid, miss_valid, cnt_up_valid, cnt_down_valid}, 0);
      chk("rst_done_rdy", {done_r_ready, done_w_ready}, 0);
      rst_n = 1;
      tick();

      run_desc(3, 0, 0, 0, 0);   // plain hit
      run_desc(5, 1, 1, 0, 0);   // lookup miss
      run_desc(5, 0, 0, 0, 1);   // hit on ID with outstanding miss
      run_desc(12, 0, 1, 4, 0);  // stalled miss
      run_desc(20, 1, 0, 3, 0);  // stall ignored on hit route

      for (int i = 0; i < 4; i++) do_done(1, 7, 1, 9);
      do_done(0, 0, 1, 33);
      do_done(1, 17, 0, 0);

      // Hold a hit, then reset mid-hold.
      desc_valid = 1; desc_id = 6'd9; desc_rw = 1; desc_miss = 0;
      tick();
      desc_valid = 0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("rst_hold", {hit_valid, out_id, out_rw}, {1'b1, 6'd9, 1'b1});
         tick();
      end
      rst_n = 0;
      #1;
      chk("midrst_valids", {hit_valid, miss_valid, cnt_up_valid}, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", desc_ready, 1);
      tick();
      rst_n = 1;
      rr_ptr_w = 0;
      tick();

      for (int n = 0; n < 60; n++) begin
         int pick;
         pick = -1;
         if ($urandom_range(0, 2) == 0) begin
            for (int k = 0; k < 8; k++) if (outstanding[k] != 0 && pick < 0) pick = k;
         end
         if (pick >= 0) begin
            if ($urandom_range(0, 1) == 1) do_done(0, 0, 1, pick);
            else                           do_done(1, pick, 0, 0);
            outstanding[pick]--;
         end else begin
            run_desc($urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 3));
         end
      end
      for (int i = 0; i < 3; i++) do_done(1, 2, 1, 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
